secuenciador_acumulador: RTL and testbench

Controls one neuron's multiply-accumulate reduction in the fixed-point neural-network datapath. On a start command it loads a bias, then accepts a programmed number of weighted-product terms over a valid/ready stream, one per cycle. Each term is summed through a saturating fixed-point adder. When all terms are in, it presents the saturated sum and a sticky saturation-error flag on a valid/ready output port for the activation stage.

---
 rtl/secuenciador_acumulador_pkg.sv | 41 ++++
 rtl/secuenciador_acumulador_if.sv | 27 ++
 rtl/secuenciador_acumulador_sumador.sv | 27 ++
 rtl/secuenciador_acumulador.sv | 140 ++++++++++++++
 tb/tb_secuenciador_acumulador.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/secuenciador_acumulador_pkg.sv
// Shared constants, state encoding and the saturating-add helper for the
// neuron multiply-accumulate sequencer.
package secuenciador_acumulador_pkg;

    localparam int Signo     = 1;
    localparam int Magnitud  = 4;
    localparam int Precision = 19;
    localparam int Width     = Signo + Magnitud + Precision;
    localparam int MaxTerms  = 64;
    localparam int CntWidth  = 7;

    localparam logic [Width-1:0]    MaxPos      = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0]    MinNeg      = {1'b1, {(Width-1){1'b0}}};
    localparam logic [CntWidth-1:0] CntZero     = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne      = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] MaxTermsCnt = CntWidth'(MaxTerms);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACUM = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {sat, sum}: overflow only happens when both operands share a sign
    // and the raw sum flips it; the result is then clamped to the matching limit.
    function automatic logic [Width:0] sat_add(input logic [Width-1:0] a,
                                               input logic [Width-1:0] b);
        logic [Width-1:0] raw;
        logic [Width:0]   res;
        raw = a + b;
        if (!a[Width-1] && !b[Width-1] && raw[Width-1]) begin
            res = {1'b1, MaxPos};
        end else if (a[Width-1] && b[Width-1] && !raw[Width-1]) begin
            res = {1'b1, MinNeg};
        end else begin
            res = {1'b0, raw};
        end
        return res;
    endfunction

endpackage

// File: rtl/secuenciador_acumulador_if.sv
// Command, term-stream and result-stream signals of the accumulator sequencer.
interface secuenciador_acumulador_if;
    import secuenciador_acumulador_pkg::*;

    logic                start;
    logic [CntWidth-1:0] num_terms;
    logic [Width-1:0]    bias;
    logic [Width-1:0]    in_data;
    logic                in_valid;
    logic                in_ready;
    logic [Width-1:0]    out_sum;
    logic                out_valid;
    logic                out_ready;
    logic                error;
    logic                busy;

    modport master (
        output start, num_terms, bias, in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_valid, error, busy
    );

    modport slave (
        input  start, num_terms, bias, in_data, in_valid, out_ready,
        output in_ready, out_sum, out_valid, error, busy
    );

endinterface

// File: rtl/secuenciador_acumulador_sumador.sv
// Purely combinational saturating fixed-point adder (sumadorPuntoFijo).
module sumadorPuntoFijo
    import secuenciador_acumulador_pkg::*;
(
    input  logic             i_enable_sum,
    input  logic [Width-1:0] i_acumulador,
    input  logic [Width-1:0] i_in,
    output logic [Width-1:0] o_sum,
    output logic             o_error
);

    logic [Width:0] w_res;

    // Saturating sum when enabled, pass-through of the accumulator otherwise.
    always_comb begin
        w_res = {1'b0, i_acumulador};
        if (i_enable_sum) begin
            w_res = sat_add(i_acumulador, i_in);
        end else begin
            w_res = {1'b0, i_acumulador};
        end
    end

    assign o_sum   = w_res[Width-1:0];
    assign o_error = w_res[Width];

endmodule

// File: rtl/secuenciador_acumulador.sv
// Sequencer for one neuron's bias + N-term saturating reduction, with
// valid/ready term input and valid/ready result output.
module secuenciador_acumulador
    import secuenciador_acumulador_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    secuenciador_acumulador_if.slave   io_bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [Width-1:0]    r_acc;
    logic [CntWidth-1:0] r_cnt;
    logic                r_error;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [Width-1:0]    w_sum;
    logic                w_sat;
    logic                w_hs;
    logic [CntWidth-1:0] w_cnt_load;
    logic                w_in_ready_nxt;
    logic                w_out_valid_nxt;
    logic                w_busy_nxt;

    assign w_hs       = r_in_ready & io_bus.in_valid;
    assign w_cnt_load = (io_bus.num_terms > MaxTermsCnt) ? MaxTermsCnt : io_bus.num_terms;

    sumadorPuntoFijo u_sumador (
        .i_enable_sum (1'b1),
        .i_acumulador (r_acc),
        .i_in         (io_bus.in_data),
        .o_sum        (w_sum),
        .o_error      (w_sat)
    );

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (io_bus.start) begin
                    w_state_nxt = (w_cnt_load == CntZero) ? DONE : ACUM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACUM: begin
                if (w_hs && (r_cnt == CntOne)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ACUM;
                end
            end
            DONE: begin
                if (io_bus.out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode of the upcoming state, captured by the state register.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (w_state_nxt)
            IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ACUM: begin
                w_in_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            DONE: begin
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Accumulator, term counter and sticky saturation flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc   <= {Width{1'b0}};
            r_cnt   <= CntZero;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_acc   <= io_bus.bias;
                        r_cnt   <= w_cnt_load;
                        r_error <= 1'b0;
                    end
                end
                ACUM: begin
                    if (w_hs) begin
                        r_acc   <= w_sum;
                        r_cnt   <= r_cnt - CntOne;
                        r_error <= r_error | w_sat;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_sum   = r_acc;
    assign io_bus.error     = r_error;
    assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_secuenciador_acumulador.sv
// Randomized scoreboard bench for secuenciador_acumulador with an
// arithmetic reference model of the saturating reduction.
module tb_secuenciador_acumulador;
    import secuenciador_acumulador_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    secuenciador_acumulador_if bus ();

    secuenciador_acumulador dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic [Width-1:0] sum;
        logic             err;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ir_cnt = 0;
    exp_t sb[$];
    logic [Width-1:0] terms[$];
    int vpat[$];
    logic hold_prev = 1'b0;
    logic [Width-1:0] sum_prev = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: result stability while stalled, scoreboard pop on output handshake.
    always @(negedge clk) begin
        if (bus.in_ready) ir_cnt <= ir_cnt + 1;
        if (rst) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_sum", 64'(bus.out_sum), 64'(sum_prev));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_sum", 64'(bus.out_sum), 64'(e.sum));
                    chk("error_flag", 64'(bus.error), 64'(e.err));
                end
            end
            hold_prev <= bus.out_valid && !bus.out_ready;
            sum_prev  <= bus.out_sum;
        end
    end

    // Reference: plain integer sum clamped to the two's-complement range after each term.
    task automatic model(input logic [Width-1:0] b, input int n_eff);
        longint acc, hi, lo;
        bit err;
        exp_t e;
        hi  = (longint'(1) << (Width - 1)) - 1;
        lo  = -(longint'(1) << (Width - 1));
        acc = longint'($signed(b));
        err = 1'b0;
        for (int k = 0; k < n_eff; k++) begin
            acc = acc + longint'($signed(terms[k]));
            if (acc > hi) begin
                acc = hi; err = 1'b1;
            end else if (acc < lo) begin
                acc = lo; err = 1'b1;
            end
        end
        e.sum = acc[Width-1:0];
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic run(input logic [Width-1:0] b, input int n, input int hold,
                       input bit chk_lat, input bit pulse_start);
        int n_eff, k, p, t0, budget;
        bit v, acc_h;
        n_eff = (n > MaxTerms) ? MaxTerms : n;
        model(b, n_eff);
        bus.start = 1'b1; bus.bias = b; bus.num_terms = CntWidth'(n);
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.bias = Width'($urandom); bus.num_terms = CntWidth'($urandom);
        k = 0; p = 0; budget = 0;
        while (k < n_eff) begin
            if (p < vpat.size()) v = (vpat[p] != 0);
            else v = ($urandom_range(0, 3) != 0);
            p++;
            bus.in_valid = v;
            bus.in_data  = v ? terms[k] : Width'($urandom);
            if (pulse_start && !v) bus.start = 1'b1;
            acc_h = v && bus.in_ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (acc_h) k++;
            budget++;
            if (budget > 1000) begin
                chk("term_timeout", 64'(k), 64'(n_eff));
                break;
            end
        end
        bus.in_valid = 1'b0;
        budget = 0;
        while (!bus.out_valid && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("out_valid_rise", 64'(bus.out_valid), 64'd1);
        if (chk_lat) chk("latency", 64'(cyc - t0), 64'(n_eff + 1));
        chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
        repeat (hold) begin
            if (pulse_start) bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.start = pulse_start;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        chk("out_valid_fall", 64'(bus.out_valid), 64'd0);
        chk("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int ir0, nr;
        bus.start = 1'b0; bus.num_terms = '0; bus.bias = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        rst = 1'b0;

        terms = '{24'h040000, 24'h040000, 24'hFC0000}; vpat = '{1, 1, 1};
        run(24'h080000, 3, 2, 1'b1, 1'b0);
        terms = '{24'h200000, 24'hF00000}; vpat = '{1, 1};
        run(24'h700000, 2, 0, 1'b1, 1'b0);
        terms = '{24'hFFFFFF}; vpat = '{1};
        run(24'h800000, 1, 1, 1'b1, 1'b0);

        terms = '{24'h013579, 24'hFEDCBA, 24'h0ABCDE, 24'h111111};
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        run(24'h123456, 4, 5, 1'b0, 1'b1);

        terms.delete(); vpat.delete();
        ir0 = ir_cnt;
        run(24'hFE0000, 0, 1, 1'b1, 1'b0);
        chk("zero_no_in_ready", 64'(ir_cnt - ir0), 64'd0);

        terms.delete(); vpat.delete();
        for (int k = 0; k < MaxTerms; k++) terms.push_back(Width'($urandom_range(0, 4095)));
        run(Width'($urandom), 100, 0, 1'b0, 1'b0);

        // Abort a reduction after two of five terms.
        bus.start = 1'b1; bus.bias = 24'h7FFFF0; bus.num_terms = 7'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 24'h300000;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_error", 64'(bus.error), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        chk("abort_out_sum", 64'(bus.out_sum), 64'd0);
        terms = '{24'h000001}; vpat = '{1};
        run(24'h000000, 1, 0, 1'b1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            nr = $urandom_range(0, 10);
            terms.delete(); vpat.delete();
            for (int k = 0; k < nr; k++) begin
                if ($urandom_range(0, 2) == 0) terms.push_back(Width'($urandom));
                else terms.push_back(Width'($signed(Width'($urandom_range(0, 65535)) - Width'(32768))));
            end
            run(Width'($urandom), nr, $urandom_range(0, 3), 1'b0, r[0]);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
